irq_controller_n: RTL

Parametrised N-channel successor to the 4-channel interrupt controller. It sits between the peripherals (uart rx, PS/2, timer and later devices) and the multi-cycle CPU's Ireq/Iack/gntInt interface. Each channel has a per-channel enable and a level/edge mode, and arbitration is either fixed-priority or round-robin. Configuration is through a Wishbone slave port on one conbus slot.

---
 rtl/irq_pkg.sv | 22 ++
 rtl/irq_rr_arbiter.sv | 37 +++
 rtl/irq_controller_n.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// Shared encodings for the N-channel interrupt controller: FSM states, register offsets and
// CTRL register bit positions.
package irq_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StAck  = 2'd2,
    StHold = 2'd3
  } state_e;

  localparam logic [1:0] REG_ENABLE  = 2'd0;
  localparam logic [1:0] REG_MODE    = 2'd1;
  localparam logic [1:0] REG_PENDING = 2'd2;
  localparam logic [1:0] REG_CTRL    = 2'd3;

  localparam int unsigned CTRL_GEN     = 0;
  localparam int unsigned CTRL_RR      = 1;
  localparam int unsigned CTRL_GNT_LSB = 8;
  localparam int unsigned CTRL_BUSY    = 31;

endpackage

// File: rtl/irq_rr_arbiter.sv
// Combinational N-way picker: lowest index wins in fixed mode, otherwise the search starts
// just after ptr and wraps around.
module irq_rr_arbiter #(
  parameter int unsigned N  = 8,
  parameter int unsigned GW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] ptr,
  input  logic          rr,
  output logic [N-1:0]  gnt,
  output logic [GW-1:0] idx
);

  int unsigned start;
  int unsigned ch;
  logic [GW-1:0] ch_idx;
  logic found;

  always_comb begin
    gnt    = '0;
    idx    = '0;
    found  = 1'b0;
    ch     = 0;
    ch_idx = '0;
    start  = rr ? ((32'(ptr) + 32'd1) % N) : 32'd0;
    for (int unsigned i = 0; i < N; i++) begin
      ch     = (start + i) % N;
      ch_idx = GW'(ch);
      if (!found && req[ch_idx]) begin
        found       = 1'b1;
        gnt[ch_idx] = 1'b1;
        idx         = ch_idx;
      end
    end
  end

endmodule

// File: rtl/irq_controller_n.sv
// N-channel interrupt controller with per-channel enable and level/edge mode, fixed or
// round-robin arbitration, and a Wishbone configuration port.
module irq_controller_n
  import irq_pkg::*;
#(
  parameter int unsigned N_IRQ    = 8,
  parameter int unsigned GW       = $clog2(N_IRQ),
  parameter bit          RR_RESET = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      dat_i,
  input  logic [31:0]      adr_i,
  input  logic             we_i,
  input  logic             stb_i,
  output logic [31:0]      dat_o,
  output logic             ack_o,
  input  logic [N_IRQ-1:0] irq_i,
  output logic [N_IRQ-1:0] iack_o,
  output logic             m0_irq_o,
  input  logic             m0_Iack_i,
  output logic [N_IRQ-1:0] i_gnt_arb,
  output logic [GW-1:0]    gnt_id
);

  logic [N_IRQ-1:0] enable_q, mode_q, edge_q, edge_d, irq_q;
  logic [N_IRQ-1:0] pending, req, arb_gnt, w1c, ack_clr;
  logic [N_IRQ-1:0] gnt_q, gnt_d;
  logic [GW-1:0]    gnt_id_q, gnt_id_d, rr_ptr_q, rr_ptr_d, arb_idx;
  logic             gen_q, rr_q, ack_q, wr_en;
  logic [31:0]      dat_q, rd_data;
  state_e           state_q, state_d;

  assign wr_en   = stb_i & we_i & ack_q;
  assign w1c     = (wr_en && adr_i[3:2] == REG_PENDING) ? dat_i[N_IRQ-1:0] : '0;
  assign ack_clr = (state_q == StAck) ? gnt_q : '0;
  // Set beats clear: a new edge arriving with a W1C or acknowledge is never lost.
  assign edge_d  = (edge_q & ~w1c & ~ack_clr) | (irq_i & ~irq_q & mode_q);
  assign pending = (mode_q & edge_q) | (~mode_q & irq_i);
  assign req     = gen_q ? (pending & enable_q) : '0;

  irq_rr_arbiter #(
    .N  (N_IRQ),
    .GW (GW)
  ) u_arb (
    .req (req),
    .ptr (rr_ptr_q),
    .rr  (rr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  always_comb begin
    rd_data = '0;
    unique case (adr_i[3:2])
      REG_ENABLE:  rd_data[N_IRQ-1:0] = enable_q;
      REG_MODE:    rd_data[N_IRQ-1:0] = mode_q;
      REG_PENDING: rd_data[N_IRQ-1:0] = pending;
      REG_CTRL: begin
        rd_data[CTRL_GEN]             = gen_q;
        rd_data[CTRL_RR]              = rr_q;
        rd_data[CTRL_GNT_LSB +: GW]   = gnt_id_q;
        rd_data[CTRL_BUSY]            = (state_q != StIdle);
      end
      default: rd_data = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          gnt_d    = arb_gnt;
          gnt_id_d = arb_idx;
          state_d  = StReq;
        end
      end
      StReq: begin
        if (m0_Iack_i) begin
          state_d = StAck;
        end else if (~|(req & gnt_q)) begin
          state_d  = StIdle;
          gnt_d    = '0;
          gnt_id_d = '0;
        end
      end
      StAck: begin
        rr_ptr_d = gnt_id_q;
        state_d  = StHold;
      end
      StHold: begin
        if (!m0_Iack_i) begin
          state_d  = StIdle;
          gnt_d    = '0;
          gnt_id_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      irq_q    <= '0;
      edge_q   <= '0;
      enable_q <= '0;
      mode_q   <= '0;
      gen_q    <= 1'b0;
      rr_q     <= RR_RESET;
      state_q  <= StIdle;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      ack_q    <= stb_i & ~ack_q;
      dat_q    <= (stb_i & ~ack_q) ? rd_data : '0;
      irq_q    <= irq_i;
      edge_q   <= edge_d;
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      rr_ptr_q <= rr_ptr_d;
      if (wr_en) begin
        unique case (adr_i[3:2])
          REG_ENABLE: enable_q <= dat_i[N_IRQ-1:0];
          REG_MODE:   mode_q   <= dat_i[N_IRQ-1:0];
          REG_CTRL: begin
            gen_q <= dat_i[CTRL_GEN];
            rr_q  <= dat_i[CTRL_RR];
          end
          default: ;
        endcase
      end
    end
  end

  assign ack_o     = ack_q;
  assign dat_o     = dat_q;
  assign m0_irq_o  = (state_q == StReq);
  assign iack_o    = ack_clr;
  assign i_gnt_arb = gnt_q;
  assign gnt_id    = gnt_id_q;

endmodule
